// File: rtl/fir_pkg.sv
// Shared definitions for the symmetric time-multiplexed FIR.
// Holds the FSM encoding, the accumulator sizing rule and the output saturation bounds.
// No logic and no state; imported by every file of the filter.
package fir_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MAC  = 2'd1,
    ST_OUT  = 2'd2
  } fir_state_t;

  // Pre-adder (dw+1) times coefficient (cw) gives dw+cw+1 bits; M such products
  // need clog2(M) growth bits so the sum can never wrap.
  function automatic int acc_width(input int dw, input int cw, input int ntap);
    return dw + cw + 1 + $clog2((ntap + 1) / 2);
  endfunction

  // Largest value representable in a dw-bit two's complement sample.
  function automatic longint sat_max(input int dw);
    return (longint'(1) <<< (dw - 1)) - 1;
  endfunction

  // Most negative value representable in a dw-bit two's complement sample.
  function automatic longint sat_min(input int dw);
    return -(longint'(1) <<< (dw - 1));
  endfunction

endpackage

// File: rtl/fir_rnd_sat.sv
// Round-half-up, arithmetic right shift and clamp of the accumulator to DW bits.
// Latency: purely combinational; the parent registers the result.
// Backpressure: none, evaluates every cycle.
module fir_rnd_sat
  import fir_pkg::*;
#(
  parameter int IW    = 29,
  parameter int DW    = 12,
  parameter int SHIFT = 11
) (
  input  logic signed [IW-1:0] acc,
  output logic signed [DW-1:0] res
);

  // One guard bit above the accumulator keeps the rounding add from wrapping.
  localparam logic signed [IW:0] HALF = (IW+1)'(longint'(1) <<< (SHIFT - 1));
  localparam logic signed [IW:0] HI   = (IW+1)'(sat_max(DW));
  localparam logic signed [IW:0] LO   = (IW+1)'(sat_min(DW));

  logic signed [IW:0] sum;
  logic signed [IW:0] shf;

  // Round, shift, then clamp to the output range.
  always_comb begin
    sum = (IW+1)'(acc) + HALF;
    shf = sum >>> SHIFT;
    if (shf > HI) begin
      res = HI[DW-1:0];
    end else if (shf < LO) begin
      res = LO[DW-1:0];
    end else begin
      res = shf[DW-1:0];
    end
  end

endmodule

// File: rtl/fir_sym_tdm.sv
// Symmetric odd-length FIR, one shared pre-adder/multiplier/accumulator stepping one tap per cycle.
// Latency: strobe cycle T0 to dout_vld is M+1 cycles, M = (NTAP+1)/2.
// Backpressure: strobes while busy are dropped and flagged in ovr; coefficient writes stall (cf_rdy=0) while busy.
module fir_sym_tdm
  import fir_pkg::*;
#(
  parameter int DW    = 12,
  parameter int CW    = 12,
  parameter int NTAP  = 31,
  parameter int SHIFT = 11
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 f_s,
  input  logic signed [DW-1:0] din,
  input  logic                 cf_we,
  input  logic [5:0]           cf_addr,
  input  logic signed [CW-1:0] cf_data,
  output logic                 cf_rdy,
  output logic signed [DW-1:0] dout,
  output logic                 dout_vld,
  output logic                 busy,
  output logic                 ovr,
  input  logic                 ovr_clr
);

  localparam int M   = (NTAP + 1) / 2;
  localparam int MH  = M - 1;
  localparam int PW  = DW + 1;
  localparam int PRW = DW + CW + 1;
  localparam int AW  = acc_width(DW, CW, NTAP);
  localparam logic [5:0] K_LAST = 6'(MH);

  if ((NTAP % 2) == 0 || NTAP < 3 || NTAP > 63) begin : g_bad_ntap
    $error("fir_sym_tdm: NTAP must be odd and within 3..63");
  end
  if (SHIFT < 1 || SHIFT > CW + 4) begin : g_bad_shift
    $error("fir_sym_tdm: SHIFT must be within 1..CW+4");
  end

  fir_state_t           state;
  logic [5:0]           k;
  logic signed [AW-1:0] acc;
  logic signed [AW-1:0] acc_nxt;
  logic signed [DW-1:0] x    [NTAP];
  logic signed [CW-1:0] coef [M];
  logic                 pl0;
  logic                 pl1;
  logic                 strobe;
  logic                 accept;
  logic                 cf_wr;
  logic signed [DW-1:0] xa;
  logic signed [DW-1:0] xb;
  logic signed [CW-1:0] ck;
  logic signed [PW-1:0] pre;
  logic signed [PRW-1:0] prod;
  logic signed [DW-1:0] rnd_out;

  assign strobe = pl0 & ~pl1;
  assign busy   = (state != ST_IDLE);
  assign cf_rdy = ~busy;
  assign accept = strobe & ~busy;
  assign cf_wr  = cf_we & cf_rdy;

  // Select the mirrored sample pair and coefficient for tap k; the centre tap has no partner.
  always_comb begin
    xa = '0;
    xb = '0;
    ck = '0;
    for (int i = 0; i < NTAP; i++) begin
      if (k == 6'(i)) xa = x[i];
      if (i != MH && k == 6'(NTAP - 1 - i)) xb = x[i];
    end
    for (int i = 0; i < M; i++) begin
      if (k == 6'(i)) ck = coef[i];
    end
    pre     = PW'(xa) + PW'(xb);
    prod    = PRW'(pre) * PRW'(ck);
    acc_nxt = acc + AW'(prod);
  end

  // The last product is folded in combinationally so dout lands with the final MAC.
  fir_rnd_sat #(
    .IW    (AW),
    .DW    (DW),
    .SHIFT (SHIFT)
  ) u_rnd_sat (
    .acc (acc_nxt),
    .res (rnd_out)
  );

  // Delay line shifts only on an accepted strobe; dropped samples leave it untouched.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NTAP; i++) x[i] <= '0;
    end else if (accept) begin
      x[0] <= din;
      for (int i = 1; i < NTAP; i++) x[i] <= x[i-1];
    end
  end

  // Coefficient bank; out-of-range indices match no entry and are ignored.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < M; i++) coef[i] <= '0;
    end else if (cf_wr) begin
      for (int i = 0; i < M; i++) begin
        if (cf_addr == 6'(i)) coef[i] <= cf_data;
      end
    end
  end

  // Strobe edge detector on f_s.
  always_ff @(posedge clk) begin
    if (rst) begin
      pl0 <= 1'b0;
      pl1 <= 1'b0;
    end else begin
      pl0 <= f_s;
      pl1 <= pl0;
    end
  end

  // Sticky overrun flag; a new overrun beats a simultaneous clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      ovr <= 1'b0;
    end else if (strobe && busy) begin
      ovr <= 1'b1;
    end else if (ovr_clr) begin
      ovr <= 1'b0;
    end
  end

  // Sequencer: IDLE waits for a strobe, MAC walks the M taps, OUT is the result cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      k        <= '0;
      acc      <= '0;
      dout     <= '0;
      dout_vld <= 1'b0;
    end else begin
      dout_vld <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (strobe) begin
            acc   <= '0;
            k     <= '0;
            state <= ST_MAC;
          end
        end
        ST_MAC: begin
          acc <= acc_nxt;
          k   <= k + 6'd1;
          if (k == K_LAST) begin
            dout     <= rnd_out;
            dout_vld <= 1'b1;
            state    <= ST_OUT;
          end
        end
        ST_OUT: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fir_sym_tdm.sv
// Randomised and directed bench for fir_sym_tdm against a direct-convolution model.
// Latency: n/a.
// Backpressure: the bench waits on cf_rdy and dout_vld with bounded loops.
module tb_fir_sym_tdm;

  localparam int DW    = 12;
  localparam int CW    = 12;
  localparam int NTAP  = 31;
  localparam int SHIFT = 11;
  localparam int M     = (NTAP + 1) / 2;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic                 f_s = 1'b0;
  logic signed [DW-1:0] din = '0;
  logic                 cf_we = 1'b0;
  logic [5:0]           cf_addr = '0;
  logic signed [CW-1:0] cf_data = '0;
  logic                 cf_rdy;
  logic signed [DW-1:0] dout;
  logic                 dout_vld;
  logic                 busy;
  logic                 ovr;
  logic                 ovr_clr = 1'b0;

  int n_cmp = 0;
  int n_err = 0;

  // Model state: half-coefficient set and full sample history, x[0] newest.
  int cm [M];
  int xh [NTAP];

  always #5 clk = ~clk;

  fir_sym_tdm #(
    .DW    (DW),
    .CW    (CW),
    .NTAP  (NTAP),
    .SHIFT (SHIFT)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .f_s      (f_s),
    .din      (din),
    .cf_we    (cf_we),
    .cf_addr  (cf_addr),
    .cf_data  (cf_data),
    .cf_rdy   (cf_rdy),
    .dout     (dout),
    .dout_vld (dout_vld),
    .busy     (busy),
    .ovr      (ovr),
    .ovr_clr  (ovr_clr)
  );

  task automatic chk(input string tag, input longint obs, input longint exp);
    n_cmp++;
    if (obs != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Full-length convolution with the mirrored impulse response h[n] = c[min(n, NTAP-1-n)].
  function automatic int model_y();
    longint s;
    longint r;
    s = 0;
    for (int n = 0; n < NTAP; n++) begin
      s += longint'(cm[(n < M) ? n : (NTAP - 1 - n)]) * longint'(xh[n]);
    end
    r = (s + (longint'(1) <<< (SHIFT - 1))) >>> SHIFT;
    if (r > 2047) r = 2047;
    if (r < -2048) r = -2048;
    return int'(r);
  endfunction

  task automatic model_push(input int d);
    for (int n = NTAP - 1; n > 0; n--) xh[n] = xh[n-1];
    xh[0] = d;
  endtask

  task automatic model_reset();
    for (int i = 0; i < M; i++) cm[i] = 0;
    for (int n = 0; n < NTAP; n++) xh[n] = 0;
  endtask

  task automatic do_reset();
    @(posedge clk) #1;
    rst = 1'b1; f_s = 1'b0; cf_we = 1'b0; ovr_clr = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    model_reset();
  endtask

  task automatic write_coef(input int addr, input int data);
    bit ok;
    ok = 1'b0;
    @(posedge clk) #1;
    cf_we = 1'b1; cf_addr = 6'(addr); cf_data = CW'(data);
    for (int c = 0; c < 40 && !ok; c++) begin
      @(negedge clk);
      if (cf_rdy) ok = 1'b1;
      else @(posedge clk) #1;
    end
    @(posedge clk) #1;
    cf_we = 1'b0;
    chk("cf_write_accept", ok, 1);
    if (ok && addr < M) cm[addr] = data;
  endtask

  // One sample: raise f_s, optionally write a coefficient in the strobe cycle, wait for dout_vld.
  task automatic run_sample(input int d, input bit wr, input int wa, input int wd, output int y);
    int lat;
    bit got;
    int exp;
    lat = 0; got = 1'b0; y = 0;
    @(posedge clk) #1;
    din = DW'(d); f_s = 1'b1;
    @(posedge clk) #1;
    if (wr) begin
      cf_we = 1'b1; cf_addr = 6'(wa); cf_data = CW'(wd);
    end
    for (int c = 1; c <= 40 && !got; c++) begin
      @(posedge clk) #1;
      if (c == 1) cf_we = 1'b0;
      if (c == 2) f_s = 1'b0;
      @(negedge clk);
      if (dout_vld) begin
        got = 1'b1; lat = c;
      end
    end
    if (wr && wa < M) cm[wa] = wd;
    model_push(d);
    exp = model_y();
    chk("latency", lat, M + 1);
    y = int'(dout);
    chk("dout", dout, exp);
    @(negedge clk);
    chk("vld_one_cycle", dout_vld, 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int y;
    int outs [NTAP];
    int vcnt;
    bit saw;
    bit got;
    bit ok;
    int exp;

    model_reset();
    do_reset();
    @(negedge clk);
    chk("rst_dout", dout, 0);
    chk("rst_vld", dout_vld, 0);
    chk("rst_busy", busy, 0);
    chk("rst_cf_rdy", cf_rdy, 1);
    chk("rst_ovr", ovr, 0);

    // All-zero coefficients, constant input.
    for (int i = 0; i < 40; i++) begin
      run_sample(1000, 1'b0, 0, 0, y);
      chk("zero_coef_out", y, 0);
    end
    chk("zero_coef_ovr", ovr, 0);

    // Edge tap impulse response.
    do_reset();
    write_coef(0, -61);
    for (int i = 0; i < NTAP; i++) run_sample((i == 0) ? 1024 : 0, 1'b0, 0, 0, outs[i]);
    chk("edge_imp_first", outs[0], -30);
    chk("edge_imp_mid", outs[15], 0);
    chk("edge_imp_last", outs[30], -30);

    // Centre tap impulse response.
    do_reset();
    write_coef(15, 1955);
    for (int i = 0; i < 16; i++) run_sample((i == 0) ? 1024 : 0, 1'b0, 0, 0, outs[i]);
    chk("centre_imp_16th", outs[15], 978);
    chk("centre_imp_1st", outs[0], 0);

    // Saturation in both directions.
    do_reset();
    for (int i = 0; i < M; i++) write_coef(i, 1024);
    for (int i = 0; i < NTAP; i++) run_sample(2047, 1'b0, 0, 0, y);
    chk("sat_pos", y, 2047);
    for (int i = 0; i < NTAP; i++) run_sample(-2048, 1'b0, 0, 0, y);
    chk("sat_neg", y, -2048);

    // Random coefficients and samples, with writes landing in the strobe cycle.
    do_reset();
    for (int i = 0; i < M; i++) write_coef(i, int'($urandom_range(0, 4095)) - 2048);
    write_coef(20, 1500);
    for (int i = 0; i < 40; i++) begin
      run_sample(int'($urandom_range(0, 4095)) - 2048, ($urandom_range(0, 3) == 0),
                 int'($urandom_range(0, 20)), int'($urandom_range(0, 4095)) - 2048, y);
    end

    // Coefficient write held while computing must wait for IDLE.
    do_reset();
    write_coef(0, 200);
    run_sample(300, 1'b0, 0, 0, y);
    @(posedge clk) #1;
    din = -12'sd400; f_s = 1'b1;
    @(posedge clk) #1;
    @(posedge clk) #1;
    cf_we = 1'b1; cf_addr = 6'd0; cf_data = -12'sd900;
    @(negedge clk);
    chk("cf_rdy_in_mac", cf_rdy, 0);
    chk("busy_in_mac", busy, 1);
    model_push(-400);
    exp = model_y();
    got = 1'b0;
    for (int c = 0; c < 40 && !got; c++) begin
      @(negedge clk);
      if (dout_vld) got = 1'b1;
    end
    chk("mac_wr_vld", got, 1);
    chk("mac_wr_old_coef", dout, exp);
    ok = 1'b0;
    for (int c = 0; c < 10 && !ok; c++) begin
      @(negedge clk);
      if (cf_rdy) ok = 1'b1;
    end
    @(posedge clk) #1;
    cf_we = 1'b0; f_s = 1'b0;
    chk("mac_wr_later_accept", ok, 1);
    cm[0] = -900;
    repeat (3) @(posedge clk);
    run_sample(50, 1'b0, 0, 0, y);
    write_coef(20, 999);
    for (int i = 0; i < 4; i++) run_sample(int'($urandom_range(0, 4095)) - 2048, 1'b0, 0, 0, y);

    // Overrun: strobe every 10 cycles, every second one is dropped.
    do_reset();
    vcnt = 0;
    for (int c = 0; c < 80; c++) begin
      @(posedge clk) #1;
      f_s = (c < 60) && ((c % 10) < 5);
      din = DW'($urandom_range(0, 4095));
      @(negedge clk);
      if (dout_vld) vcnt++;
    end
    chk("ovr_vld_count", vcnt, 3);
    chk("ovr_sticky", ovr, 1);
    chk("ovr_busy_idle", busy, 0);
    @(posedge clk) #1 ovr_clr = 1'b1;
    @(posedge clk) #1 ovr_clr = 1'b0;
    @(negedge clk);
    chk("ovr_cleared", ovr, 0);

    // Overrun coinciding with a held clear still raises the flag.
    saw = 1'b0;
    ovr_clr = 1'b1;
    for (int c = 0; c < 30; c++) begin
      @(posedge clk) #1;
      f_s = (c < 15) && ((c % 10) < 5);
      @(negedge clk);
      if (ovr) saw = 1'b1;
    end
    @(posedge clk) #1 ovr_clr = 1'b0;
    @(negedge clk);
    chk("ovr_set_wins", saw, 1);
    chk("ovr_after_clr", ovr, 0);

    // Reset in cycle T5 aborts the computation silently.
    do_reset();
    write_coef(0, 100);
    run_sample(700, 1'b0, 0, 0, y);
    @(posedge clk) #1;
    din = 12'sd500; f_s = 1'b1;
    @(posedge clk) #1;
    repeat (5) @(posedge clk);
    #1 rst = 1'b1; f_s = 1'b0;
    @(posedge clk) #1 rst = 1'b0;
    model_reset();
    @(negedge clk);
    chk("abort_busy", busy, 0);
    chk("abort_dout", dout, 0);
    chk("abort_vld", dout_vld, 0);
    chk("abort_cf_rdy", cf_rdy, 1);
    vcnt = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (dout_vld) vcnt++;
    end
    chk("abort_no_vld", vcnt, 0);
    run_sample(1234, 1'b0, 0, 0, y);
    chk("abort_coefs_cleared", y, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
